// File: rtl/riscv_core_pkg.sv
// Shared types for the integer pipeline forwarding controller.
package riscv_core_pkg;

  // Register index width carried in a shadow entry
  localparam int RV_REGW = 5;

  // Operand source select driven to the EX-stage operand muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_WB1 = 2'b11
  } fwd_sel_e;

  // Destination info for one in-flight instruction
  typedef struct packed {
    logic               valid;
    logic [RV_REGW-1:0] rd;
    logic               is_load;
  } fwd_entry_t;

endpackage

// File: rtl/riscv_core_fwd_cmp.sv
// Per-operand comparator and youngest-first priority encoder.
// The entries seen here are the shadow state of the cycle in which the
// consumer is in ID. The selects name where the value will be when the
// consumer reaches EX, one stage further down.
module riscv_core_fwd_cmp
  import riscv_core_pkg::*;
(
  input  logic               i_use,
  input  logic [RV_REGW-1:0] i_rs,
  input  logic               i_ex_valid,
  input  logic [RV_REGW-1:0] i_ex_rd,
  input  logic               i_ex_is_load,
  input  logic               i_mem_valid,
  input  logic [RV_REGW-1:0] i_mem_rd,
  input  logic               i_wb_valid,
  input  logic [RV_REGW-1:0] i_wb_rd,
  output fwd_sel_e           o_sel,
  output logic               o_ex_load_hit
);

  logic w_live;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  // x0 is hardwired to zero, so it is never forwarded
  assign w_live    = i_use & (i_rs != '0);
  assign w_hit_ex  = w_live & i_ex_valid  & (i_ex_rd  == i_rs);
  assign w_hit_mem = w_live & i_mem_valid & (i_mem_rd == i_rs);
  assign w_hit_wb  = w_live & i_wb_valid  & (i_wb_rd  == i_rs);

  // A load in EX has no data until MEM, so the consumer must wait a cycle
  assign o_ex_load_hit = w_hit_ex & i_ex_is_load;

  // Youngest producer wins
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex)       o_sel = FWD_MEM;
    else if (w_hit_mem) o_sel = FWD_WB;
    else if (w_hit_wb)  o_sel = FWD_WB1;
  end

endmodule

// File: rtl/riscv_core_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow copy of the destination info of each in-flight
// instruction and registers the EX operand selects one cycle ahead.
// REGW must not exceed the package register width RV_REGW.
module riscv_core_fwd_ctrl
  import riscv_core_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fwd_id_valid,
  input  logic [REGW-1:0] i_fwd_id_rs1,
  input  logic [REGW-1:0] i_fwd_id_rs2,
  input  logic            i_fwd_id_use_rs1,
  input  logic            i_fwd_id_use_rs2,
  input  logic [REGW-1:0] i_fwd_id_rd,
  input  logic            i_fwd_id_wen,
  input  logic            i_fwd_id_is_load,
  input  logic            i_fwd_flush,
  input  logic            i_fwd_hold,
  output logic [1:0]      o_fwd_sel_rs1,
  output logic [1:0]      o_fwd_sel_rs2,
  output logic            o_fwd_stall
);

  localparam fwd_entry_t BUBBLE = '{valid: 1'b0, rd: '0, is_load: 1'b0};

  fwd_entry_t r_ex;
  fwd_entry_t r_mem;
  fwd_entry_t r_wb;
  fwd_entry_t r_wb1;
  fwd_sel_e   r_sel_rs1;
  fwd_sel_e   r_sel_rs2;

  fwd_sel_e   w_sel_rs1;
  fwd_sel_e   w_sel_rs2;
  logic       w_hit_rs1;
  logic       w_hit_rs2;
  logic       w_stall;
  logic       w_id_issue;
  fwd_entry_t w_id_entry;

  riscv_core_fwd_cmp u_cmp_rs1 (
    .i_use         (i_fwd_id_use_rs1),
    .i_rs          (RV_REGW'(i_fwd_id_rs1)),
    .i_ex_valid    (r_ex.valid),
    .i_ex_rd       (r_ex.rd),
    .i_ex_is_load  (r_ex.is_load),
    .i_mem_valid   (r_mem.valid),
    .i_mem_rd      (r_mem.rd),
    .i_wb_valid    (r_wb.valid),
    .i_wb_rd       (r_wb.rd),
    .o_sel         (w_sel_rs1),
    .o_ex_load_hit (w_hit_rs1)
  );

  riscv_core_fwd_cmp u_cmp_rs2 (
    .i_use         (i_fwd_id_use_rs2),
    .i_rs          (RV_REGW'(i_fwd_id_rs2)),
    .i_ex_valid    (r_ex.valid),
    .i_ex_rd       (r_ex.rd),
    .i_ex_is_load  (r_ex.is_load),
    .i_mem_valid   (r_mem.valid),
    .i_mem_rd      (r_mem.rd),
    .i_wb_valid    (r_wb.valid),
    .i_wb_rd       (r_wb.rd),
    .o_sel         (w_sel_rs2),
    .o_ex_load_hit (w_hit_rs2)
  );

  // A killed ID instruction cannot stall; hold deliberately does not gate it
  assign w_stall = i_fwd_id_valid & ~i_fwd_flush & (w_hit_rs1 | w_hit_rs2);

  // The ID instruction enters EX only when it is real, not stalled and not killed
  assign w_id_issue = i_fwd_id_valid & ~w_stall & ~i_fwd_flush;

  assign w_id_entry = '{
    valid:   w_id_issue & i_fwd_id_wen & (i_fwd_id_rd != '0),
    rd:      RV_REGW'(i_fwd_id_rd),
    is_load: i_fwd_id_is_load
  };

  // Advance the shadow pipeline and capture the selects for the next EX cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex      <= BUBBLE;
      r_mem     <= BUBBLE;
      r_wb      <= BUBBLE;
      r_wb1     <= BUBBLE;
      r_sel_rs1 <= FWD_RF;
      r_sel_rs2 <= FWD_RF;
    end else if (!i_fwd_hold) begin
      r_wb1     <= r_wb;
      r_wb      <= r_mem;
      r_mem     <= i_fwd_flush ? BUBBLE : r_ex;
      r_ex      <= w_id_entry;
      r_sel_rs1 <= w_id_issue ? w_sel_rs1 : FWD_RF;
      r_sel_rs2 <= w_id_issue ? w_sel_rs2 : FWD_RF;
    end
  end

  assign o_fwd_sel_rs1 = r_sel_rs1;
  assign o_fwd_sel_rs2 = r_sel_rs2;
  assign o_fwd_stall   = w_stall;

endmodule

// File: tb/tb_riscv_core_fwd_ctrl.sv
// Directed self-checking bench for the forwarding and load-use controller.
module tb_riscv_core_fwd_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_fwd_id_valid;
  logic [4:0] i_fwd_id_rs1;
  logic [4:0] i_fwd_id_rs2;
  logic       i_fwd_id_use_rs1;
  logic       i_fwd_id_use_rs2;
  logic [4:0] i_fwd_id_rd;
  logic       i_fwd_id_wen;
  logic       i_fwd_id_is_load;
  logic       i_fwd_flush;
  logic       i_fwd_hold;
  logic [1:0] o_fwd_sel_rs1;
  logic [1:0] o_fwd_sel_rs2;
  logic       o_fwd_stall;

  int checks   = 0;
  int failures = 0;

  riscv_core_fwd_ctrl #(.REGW(5)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_fwd_id_valid   (i_fwd_id_valid),
    .i_fwd_id_rs1     (i_fwd_id_rs1),
    .i_fwd_id_rs2     (i_fwd_id_rs2),
    .i_fwd_id_use_rs1 (i_fwd_id_use_rs1),
    .i_fwd_id_use_rs2 (i_fwd_id_use_rs2),
    .i_fwd_id_rd      (i_fwd_id_rd),
    .i_fwd_id_wen     (i_fwd_id_wen),
    .i_fwd_id_is_load (i_fwd_id_is_load),
    .i_fwd_flush      (i_fwd_flush),
    .i_fwd_hold       (i_fwd_hold),
    .o_fwd_sel_rs1    (o_fwd_sel_rs1),
    .o_fwd_sel_rs2    (o_fwd_sel_rs2),
    .o_fwd_stall      (o_fwd_stall)
  );

  // Free-running core clock, 10 time units per cycle
  always #5 i_clk = ~i_clk;

  // Advance one clock and settle just past the rising edge
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Present one ID-stage instruction and let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic wen,
                               input logic ld, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
    i_fwd_id_valid   = v;
    i_fwd_id_rd      = rd;
    i_fwd_id_wen     = wen;
    i_fwd_id_is_load = ld;
    i_fwd_id_rs1     = rs1;
    i_fwd_id_use_rs1 = u1;
    i_fwd_id_rs2     = rs2;
    i_fwd_id_use_rs2 = u2;
    #1;
  endtask

  // Drain the shadow pipeline with bubbles
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      cyc();
    end
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_fwd_flush = 1'b0;
    i_fwd_hold  = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #10;
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_sel_rs1 got=%b exp=00", o_fwd_sel_rs1);
    end
    checks++;
    if (o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_sel_rs2 got=%b exp=00", o_fwd_sel_rs2);
    end
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_stall got=%b exp=0", o_fwd_stall);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc();
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_stall got=%b exp=0", o_fwd_stall);
    end
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b01) begin
      failures++; $display("[TB] FAIL b2b_sel_rs1 got=%b exp=01", o_fwd_sel_rs1);
    end
    checks++;
    if (o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL b2b_sel_rs2 got=%b exp=00", o_fwd_sel_rs2);
    end
  endtask

  task automatic test_distance();
    logic [1:0] expSel [2:4];
    expSel[2] = 2'b10;
    expSel[3] = 2'b11;
    expSel[4] = 2'b00;
    for (int d = 2; d <= 4; d++) begin
      idle(4);
      applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      cyc();
      idle(d - 1);
      applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1);
      cyc();
      checks++;
      if (o_fwd_sel_rs1 !== expSel[d]) begin
        failures++; $display("[TB] FAIL dist%0d_sel_rs1 got=%b exp=%b", d, o_fwd_sel_rs1, expSel[d]);
      end
      checks++;
      if (o_fwd_sel_rs2 !== 2'b00) begin
        failures++; $display("[TB] FAIL dist%0d_sel_rs2 got=%b exp=00", d, o_fwd_sel_rs2);
      end
    end
  endtask

  task automatic test_load_use();
    idle(4);
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1);
    checks++;
    if (o_fwd_stall !== 1'b1) begin
      failures++; $display("[TB] FAIL lu_stall_first got=%b exp=1", o_fwd_stall);
    end
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00 || o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL lu_bubble_sel got=%b/%b exp=00/00", o_fwd_sel_rs1, o_fwd_sel_rs2);
    end
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL lu_stall_second got=%b exp=0", o_fwd_stall);
    end
    cyc();
    checks++;
    if (o_fwd_sel_rs2 !== 2'b10) begin
      failures++; $display("[TB] FAIL lu_sel_rs2 got=%b exp=10", o_fwd_sel_rs2);
    end
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL lu_sel_rs1 got=%b exp=00", o_fwd_sel_rs1);
    end
  endtask

  task automatic test_priority_x0();
    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b01) begin
      failures++; $display("[TB] FAIL prio_sel_rs1 got=%b exp=01", o_fwd_sel_rs1);
    end
    checks++;
    if (o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL prio_unused_rs2 got=%b exp=00", o_fwd_sel_rs2);
    end

    idle(4);
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL x0_sel_rs1 got=%b exp=00", o_fwd_sel_rs1);
    end

    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL nowen_sel_rs1 got=%b exp=00", o_fwd_sel_rs1);
    end

    idle(4);
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL lwx0_stall got=%b exp=0", o_fwd_stall);
    end
    cyc();
  endtask

  task automatic test_flush();
    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    i_fwd_flush = 1'b1;
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_stall got=%b exp=0", o_fwd_stall);
    end
    cyc();
    i_fwd_flush = 1'b0;
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL flush_bubble_sel got=%b exp=00", o_fwd_sel_rs1);
    end
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_next_stall got=%b exp=0", o_fwd_stall);
    end
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00) begin
      failures++; $display("[TB] FAIL flush_next_sel got=%b exp=00", o_fwd_sel_rs1);
    end
  endtask

  task automatic test_hold();
    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b01 || o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL hold_pre_sel got=%b/%b exp=01/00", o_fwd_sel_rs1, o_fwd_sel_rs2);
    end
    i_fwd_hold = 1'b1;
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1);
    for (int h = 0; h < 3; h++) begin
      i_fwd_flush = (h == 2);
      cyc();
      checks++;
      if (o_fwd_sel_rs1 !== 2'b01 || o_fwd_sel_rs2 !== 2'b00) begin
        failures++; $display("[TB] FAIL hold%0d_sel got=%b/%b exp=01/00", h, o_fwd_sel_rs1, o_fwd_sel_rs2);
      end
    end
    i_fwd_hold  = 1'b0;
    i_fwd_flush = 1'b0;
    applyStimulus(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b10 || o_fwd_sel_rs2 !== 2'b01) begin
      failures++; $display("[TB] FAIL hold_resume_sel got=%b/%b exp=10/01", o_fwd_sel_rs1, o_fwd_sel_rs2);
    end
  endtask

  task automatic test_reset_mid();
    idle(4);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b01) begin
      failures++; $display("[TB] FAIL rstmid_pre_sel got=%b exp=01", o_fwd_sel_rs1);
    end
    applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1);
    checks++;
    if (o_fwd_stall !== 1'b1) begin
      failures++; $display("[TB] FAIL rstmid_pre_stall got=%b exp=1", o_fwd_stall);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_stall got=%b exp=0", o_fwd_stall);
    end
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00 || o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL rstmid_sel got=%b/%b exp=00/00", o_fwd_sel_rs1, o_fwd_sel_rs2);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_fwd_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_post_stall got=%b exp=0", o_fwd_stall);
    end
    cyc();
    checks++;
    if (o_fwd_sel_rs1 !== 2'b00 || o_fwd_sel_rs2 !== 2'b00) begin
      failures++; $display("[TB] FAIL rstmid_post_sel got=%b/%b exp=00/00", o_fwd_sel_rs1, o_fwd_sel_rs2);
    end
  endtask

  // Run every scenario in sequence and report once
  initial begin
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_priority_x0();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
